dbus_bridge: RTL and testbench

Data-side bus bridge sitting directly downstream of the single-cycle CPU's data port. It consumes the CPU's ALU address, store data and memory-write strobe, and decodes them to either the external data RAM or a small memory-mapped I/O region. That region holds a programmable down-counting timer with interrupt and an LED output register. Read data returns combinationally in the same cycle so the single-cycle datapath needs no stall logic.

---
 rtl/dbus_bridge_pkg.sv | 20 ++
 rtl/dbus_bridge_timer_core.sv | 97 +++++++++
 rtl/dbus_bridge.sv | 75 +++++++
 tb/tb_dbus_bridge.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dbus_bridge_pkg.sv
// Shared constants for the data-side bus bridge: MMIO register offsets,
// CTRL bit positions and timer mode encodings.
package dbus_bridge_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_LEDS   = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 2;
  localparam int CTRL_PEND = 3;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_RELOAD  = 1'b1
  } timer_mode_e;

endpackage

// File: rtl/dbus_bridge_timer_core.sv
// Programmable down-counting timer: CTRL/PRESET/COUNT registers, terminal
// event handling and level interrupt.
module timer_core
  import dbus_bridge_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_we_i,
  input  logic        preset_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ctrl_o,
  output logic [31:0] preset_o,
  output logic [31:0] count_o,
  output logic        irq_o
);

  logic             en_q, en_d;
  timer_mode_e      mode_q, mode_d;
  logic             im_q, im_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             terminal;

  assign terminal = en_q && (count_q == CNT_W'(1));

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    pend_d   = pend_q;
    preset_d = preset_q;
    count_d  = count_q;

    if (en_q && (count_q != '0)) begin
      if (terminal) begin
        if ((mode_q == MODE_RELOAD) && (preset_q != '0)) begin
          count_d = preset_q;
        end else begin
          count_d = '0;
          en_d    = 1'b0;
        end
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // CPU write overrides timer updates, except a one-shot terminal still stops the timer.
    if (ctrl_we_i) begin
      en_d   = wdata_i[CTRL_EN] && !(terminal && (mode_q == MODE_ONESHOT));
      mode_d = timer_mode_e'(wdata_i[CTRL_MODE]);
      im_d   = wdata_i[CTRL_IM];
      if (wdata_i[CTRL_PEND]) pend_d = 1'b0;
    end
    if (terminal) pend_d = 1'b1;

    if (preset_we_i) begin
      preset_d = wdata_i[CNT_W-1:0];
      count_d  = wdata_i[CNT_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ctrl_o            = '0;
    ctrl_o[CTRL_EN]   = en_q;
    ctrl_o[CTRL_MODE] = mode_q;
    ctrl_o[CTRL_IM]   = im_q;
    ctrl_o[CTRL_PEND] = pend_q;
  end

  assign preset_o = 32'(preset_q);
  assign count_o  = 32'(count_q);
  assign irq_o    = pend_q & im_q;

endmodule

// File: rtl/dbus_bridge.sv
// Data-side bus bridge: decodes CPU data accesses to RAM or a 16-byte MMIO
// window (timer + LEDs) with a combinational read path.
module dbus_bridge
  import dbus_bridge_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] MMIO_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic [31:0] leds,
  output logic        irq
);

  logic        hit;
  logic [1:0]  off;
  logic        mmio_we;
  logic [31:0] leds_q, leds_d;
  logic [31:0] ctrl_rd, preset_rd, count_rd;
  logic        unused_byte_sel;

  assign hit     = (addr[31:4] == MMIO_BASE[31:4]);
  assign off     = addr[3:2];
  assign mmio_we = we && hit;
  // Word access only: the byte-select bits carry no meaning here.
  assign unused_byte_sel = &{1'b0, addr[1:0]};

  assign ram_addr  = addr;
  assign ram_wdata = wdata;
  assign ram_we    = we && !hit;

  timer_core #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .ctrl_we_i  (mmio_we && (off == OFF_CTRL)),
    .preset_we_i(mmio_we && (off == OFF_PRESET)),
    .wdata_i    (wdata),
    .ctrl_o     (ctrl_rd),
    .preset_o   (preset_rd),
    .count_o    (count_rd),
    .irq_o      (irq)
  );

  assign leds_d = (mmio_we && (off == OFF_LEDS)) ? wdata : leds_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) leds_q <= '0;
    else     leds_q <= leds_d;
  end

  assign leds = leds_q;

  always_comb begin
    rdata = ram_rdata;
    if (hit) begin
      case (off)
        OFF_CTRL:   rdata = ctrl_rd;
        OFF_PRESET: rdata = preset_rd;
        OFF_COUNT:  rdata = count_rd;
        default:    rdata = leds_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed testbench for dbus_bridge: decode, RAM passthrough, timer modes,
// same-cycle collisions, masking and reset.
module tb_dbus_bridge;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_LEDS   = 32'h0000_7F0C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata, ram_addr, ram_wdata, ram_rdata, leds;
  logic        we, ram_we, irq;
  int          n_checks = 0;
  int          n_fail   = 0;

  dbus_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata),
    .leds     (leds),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    we   = 1'b0;
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1;
    n_checks++; if (leds !== 32'h0) begin n_fail++; $display("FAIL por_leds: got %h expected %h", leds, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL por_irq: got %b expected 0", irq); end
    we = 1'b1; addr = A_LEDS; #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL por_ram_we_mmio: got %b expected 0", ram_we); end
    we = 1'b0;
    @(negedge clk); rst = 1'b0;

    bus_write(A_CTRL, 32'h1);
    bus_write(A_LEDS, 32'hA5);
    bus_write(A_PRESET, 32'd5);
    @(posedge clk); @(posedge clk); #1;
    rd(A_COUNT, v);
    n_checks++; if (v !== 32'd3) begin n_fail++; $display("FAIL midcount_count: got %h expected %h", v, 32'd3); end
    #2; rst = 1'b1; #1;
    rd(A_COUNT, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_count: got %h expected %h", v, 32'h0); end
    rd(A_CTRL, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h expected %h", v, 32'h0); end
    rd(A_PRESET, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL rst_preset: got %h expected %h", v, 32'h0); end
    n_checks++; if (leds !== 32'h0) begin n_fail++; $display("FAIL rst_leds: got %h expected %h", leds, 32'h0); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_ram_passthrough();
    logic [31:0] v;
    do_reset();
    @(negedge clk);
    addr = 32'h100; wdata = 32'hDEAD_BEEF; we = 1'b1; #1;
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL ram_we: got %b expected 1", ram_we); end
    n_checks++; if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL ram_addr: got %h expected %h", ram_addr, 32'h100); end
    n_checks++; if (ram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_wdata: got %h expected %h", ram_wdata, 32'hDEAD_BEEF); end
    we = 1'b0; ram_rdata = 32'h1234;
    rd(32'h100, v);
    n_checks++; if (v !== 32'h1234) begin n_fail++; $display("FAIL ram_read: got %h expected %h", v, 32'h1234); end
    rd(32'h7F10, v);
    n_checks++; if (v !== 32'h1234) begin n_fail++; $display("FAIL ram_read_above_window: got %h expected %h", v, 32'h1234); end
    @(negedge clk);
    addr = A_LEDS; wdata = 32'hCAFE_F00D; we = 1'b1; #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL mmio_ram_we: got %b expected 0", ram_we); end
    @(posedge clk); #1; we = 1'b0;
    n_checks++; if (leds !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL leds_write: got %h expected %h", leds, 32'hCAFE_F00D); end
    rd(A_LEDS, v);
    n_checks++; if (v !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL leds_read: got %h expected %h", v, 32'hCAFE_F00D); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    bus_write(A_CTRL, 32'h5);
    bus_write(A_PRESET, 32'd3);
    rd(A_COUNT, v);
    n_checks++; if (v !== 32'd3) begin n_fail++; $display("FAIL os_count_load: got %h expected %h", v, 32'd3); end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      rd(A_COUNT, v);
      n_checks++; if (v !== 32'(3 - i)) begin n_fail++; $display("FAIL os_count_step%0d: got %h expected %h", i, v, 32'(3 - i)); end
      n_checks++; if (irq !== (i == 3)) begin n_fail++; $display("FAIL os_irq_step%0d: got %b expected %b", i, irq, (i == 3)); end
    end
    rd(A_CTRL, v);
    n_checks++; if (v !== 32'hC) begin n_fail++; $display("FAIL os_ctrl_after: got %h expected %h", v, 32'hC); end
    @(posedge clk); #1;
    rd(A_COUNT, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL os_count_stays0: got %h expected %h", v, 32'h0); end
  endtask

  task automatic test_autoreload_and_collisions();
    logic [31:0] v;
    logic [31:0] exp_seq [8] = '{32'd3, 32'd2, 32'd1, 32'd4, 32'd3, 32'd2, 32'd1, 32'd4};
    do_reset();
    bus_write(A_CTRL, 32'h7);
    bus_write(A_PRESET, 32'd4);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rd(A_COUNT, v);
      n_checks++; if (v !== exp_seq[i]) begin n_fail++; $display("FAIL ar_count_step%0d: got %h expected %h", i, v, exp_seq[i]); end
      if (i == 2 || i == 3) begin
        n_checks++; if (irq !== (i == 3)) begin n_fail++; $display("FAIL ar_irq_step%0d: got %b expected %b", i, irq, (i == 3)); end
      end
    end
    bus_write(A_CTRL, 32'hF);
    rd(A_CTRL, v);
    n_checks++; if (v !== 32'h7) begin n_fail++; $display("FAIL ar_pend_clear: got %h expected %h", v, 32'h7); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq_clear: got %b expected 0", irq); end

    @(posedge clk); @(posedge clk); #1;
    rd(A_COUNT, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL col_pre_terminal: got %h expected %h", v, 32'd1); end
    bus_write(A_CTRL, 32'hF);
    rd(A_CTRL, v);
    n_checks++; if (v !== 32'hF) begin n_fail++; $display("FAIL col_set_wins: got %h expected %h", v, 32'hF); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL col_irq: got %b expected 1", irq); end
    bus_write(A_PRESET, 32'd9);
    rd(A_COUNT, v);
    n_checks++; if (v !== 32'd9) begin n_fail++; $display("FAIL col_preset_wins: got %h expected %h", v, 32'd9); end

    do_reset();
    bus_write(A_CTRL, 32'h1);
    bus_write(A_PRESET, 32'd2);
    @(posedge clk); #1;
    bus_write(A_CTRL, 32'h1);
    rd(A_CTRL, v);
    n_checks++; if (v !== 32'h8) begin n_fail++; $display("FAIL col_oneshot_en_clears: got %h expected %h", v, 32'h8); end
  endtask

  task automatic test_masking();
    logic [31:0] v;
    do_reset();
    bus_write(A_CTRL, 32'h1);
    bus_write(A_PRESET, 32'd6);
    bus_write(A_COUNT, 32'h55);
    rd(A_COUNT, v);
    n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL count_write_ignored: got %h expected %h", v, 32'd5); end
    repeat (5) @(posedge clk);
    #1;
    rd(A_CTRL, v);
    n_checks++; if (v !== 32'h8) begin n_fail++; $display("FAIL mask_pend: got %h expected %h", v, 32'h8); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq: got %b expected 0", irq); end
    bus_write(A_CTRL, 32'hFFFF_FFF6);
    rd(A_CTRL, v);
    n_checks++; if (v !== 32'hE) begin n_fail++; $display("FAIL ctrl_upper_zero: got %h expected %h", v, 32'hE); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL unmask_irq: got %b expected 1", irq); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; ram_rdata = '0;
    test_reset();
    test_ram_passthrough();
    test_oneshot();
    test_autoreload_and_collisions();
    test_masking();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
